sweep_ctrl: RTL and testbench

- Sequences an up/down counter datapath to produce triangle sweeps between programmable bounds lo and hi.
- Drives the direction (dir, equivalent to is_up) and owns the count register.
- Handles the start/stop handshake, counts completed sweeps and pulses done.
- Sits between the register/config interface and downstream consumers of count (DAC ramp, PWM compare, scan address).

---
 rtl/sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_sweep_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - triangle sweep sequencer between latched lo/hi bounds
// Optional hold at each bound: define SWEEP_CTRL_DWELL_EN.
module sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int NSW_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [NSW_W-1:0] n_sweeps,
`ifdef SWEEP_CTRL_DWELL_EN
    input  logic [7:0]       dwell,
`endif
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [NSW_W-1:0] n_q;
    logic [NSW_W-1:0] sweep_q;
    logic [NSW_W-1:0] sweep_d;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             hold_end;

    assign sweep_d = sweep_q + 1'b1;

    // hold_end gates turns/completions; without dwell a bound is left on its first cycle
`ifdef SWEEP_CTRL_DWELL_EN
    logic [7:0] dwell_q;
    logic [7:0] dcnt_q;
    assign hold_end = (dcnt_q == dwell_q);
`else
    assign hold_end = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            count_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            n_q     <= '0;
            sweep_q <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
            dwell_q <= '0;
            dcnt_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (lo < hi) begin
                            lo_q    <= lo;
                            hi_q    <= hi;
                            n_q     <= n_sweeps;
                            sweep_q <= '0;
                            count_q <= lo;
                            state_q <= S_UP;
                            dir_q   <= 1'b1;
                            busy_q  <= 1'b1;
`ifdef SWEEP_CTRL_DWELL_EN
                            dwell_q <= dwell;
                            dcnt_q  <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_UP: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        dir_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (count_q == hi_q) begin
                        if (hold_end) begin
                            count_q <= hi_q - 1'b1;
                            state_q <= S_DOWN;
                            dir_q   <= 1'b0;
`ifdef SWEEP_CTRL_DWELL_EN
                            dcnt_q  <= '0;
                        end else begin
                            dcnt_q  <= dcnt_q + 8'd1;
`endif
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        dir_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (count_q == lo_q) begin
                        if (hold_end) begin
                            sweep_q <= sweep_d;
                            if (n_q != '0 && sweep_d == n_q) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                count_q <= lo_q + 1'b1;
                                state_q <= S_UP;
                                dir_q   <= 1'b1;
                            end
`ifdef SWEEP_CTRL_DWELL_EN
                            dcnt_q  <= '0;
                        end else begin
                            dcnt_q  <= dcnt_q + 8'd1;
`endif
                        end
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign count   = count_q;
    assign dir     = dir_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - randomized self-checking bench for sweep_ctrl
// Dwell cases run only when SWEEP_CTRL_DWELL_EN is defined.
module tb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] lo = '0;
    logic [7:0] hi = '0;
    logic [7:0] n_sweeps = '0;
`ifdef SWEEP_CTRL_DWELL_EN
    logic [7:0] dwell = '0;
`endif
    logic [7:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int n_tests = 0;
    int n_fail = 0;
    int last_cnt = 0;
    int exp_cnt[$];
    int exp_dir[$];

    sweep_ctrl #(.WIDTH(8), .NSW_W(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .lo       (lo),
        .hi       (hi),
        .n_sweeps (n_sweeps),
`ifdef SWEEP_CTRL_DWELL_EN
        .dwell    (dwell),
`endif
        .count    (count),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int c, input int d, input int b,
                             input int dn, input int e);
        check({tag, ".count"},   int'(count),   c);
        check({tag, ".dir"},     int'(dir),     d);
        check({tag, ".busy"},    int'(busy),    b);
        check({tag, ".done"},    int'(done),    dn);
        check({tag, ".cfg_err"}, int'(cfg_err), e);
    endtask

    // Expected trace: initial lo, then per sweep the climb, a dwell at hi, the descent, a dwell at lo
    task automatic build(input int l, input int h, input int nb, input int d);
        exp_cnt.delete();
        exp_dir.delete();
        exp_cnt.push_back(l); exp_dir.push_back(1);
        for (int s = 0; s < nb; s++) begin
            for (int v = l + 1; v < h; v++) begin
                exp_cnt.push_back(v); exp_dir.push_back(1);
            end
            for (int k = 0; k <= d; k++) begin
                exp_cnt.push_back(h); exp_dir.push_back(1);
            end
            for (int v = h - 1; v > l; v--) begin
                exp_cnt.push_back(v); exp_dir.push_back(0);
            end
            for (int k = 0; k <= d; k++) begin
                exp_cnt.push_back(l); exp_dir.push_back(0);
            end
        end
    endtask

    task automatic scramble();
        lo       = 8'($urandom);
        hi       = 8'($urandom);
        n_sweeps = 8'($urandom);
        start    = ($urandom_range(0, 3) == 0);
`ifdef SWEEP_CTRL_DWELL_EN
        dwell    = 8'($urandom);
`endif
    endtask

    task automatic run_case(input int l, input int h, input int n, input int d, input int stop_at);
        lo       = 8'(l);
        hi       = 8'(h);
        n_sweeps = 8'(n);
`ifdef SWEEP_CTRL_DWELL_EN
        dwell    = 8'(d);
`endif
        start    = 1'b1;
        build(l, h, (n == 0) ? 5 : n, d);
        for (int i = 0; i < exp_cnt.size(); i++) begin
            step();
            check_out("run", exp_cnt[i], exp_dir[i], 1, 0, 0);
            scramble();
            if (i == stop_at) begin
                stop = 1'b1;
                step();
                check_out("stop", exp_cnt[i], 0, 0, 0, 0);
                stop  = 1'b0;
                start = 1'b0;
                step();
                check_out("stop_hold", exp_cnt[i], 0, 0, 0, 0);
                last_cnt = exp_cnt[i];
                return;
            end
        end
        step();
        check_out("done", l, 0, 0, 1, 0);
        start = 1'b0;
        stop  = 1'($urandom);
        step();
        check_out("idle", l, 0, 0, 0, 0);
        stop = 1'b0;
        step();
        check_out("idle_hold", l, 0, 0, 0, 0);
        last_cnt = l;
    endtask

    task automatic err_case(input int l, input int h);
        lo    = 8'(l);
        hi    = 8'(h);
        start = 1'b1;
        step();
        check_out("cfg", last_cnt, 0, 0, 0, 1);
        start = 1'b0;
        step();
        check_out("cfg_after", last_cnt, 0, 0, 0, 0);
    endtask

    initial begin
        int l, h, n, d, sa, sz;

        rstn = 1'b0;
        step();
        step();
        check_out("reset", 0, 0, 0, 0, 0);
        rstn = 1'b1;
        step();
        check_out("reset_rel", 0, 0, 0, 0, 0);
        step();
        check_out("reset_idle", 0, 0, 0, 0, 0);

        run_case(2, 5, 1, 0, -1);
        run_case(0, 3, 0, 0, 20);
        err_case(7, 7);
        err_case(8, 3);
        run_case(10, 11, 3, 0, -1);

        lo = 8'd10; hi = 8'd11; n_sweeps = 8'd3; start = 1'b1;
        step();
        check_out("mr0", 10, 1, 1, 0, 0);
        start = 1'b0;
        step();
        check_out("mr1", 11, 1, 1, 0, 0);
        rstn = 1'b0;
        step();
        check_out("mid_reset", 0, 0, 0, 0, 0);
        rstn = 1'b1;
        step();
        check_out("mid_reset_rel", 0, 0, 0, 0, 0);
        last_cnt = 0;

`ifdef SWEEP_CTRL_DWELL_EN
        run_case(1, 3, 1, 2, -1);
`endif

        for (int it = 0; it < 40; it++) begin
            l = $urandom_range(0, 240);
            h = l + $urandom_range(1, 12);
            n = $urandom_range(0, 3);
            d = 0;
`ifdef SWEEP_CTRL_DWELL_EN
            d = $urandom_range(0, 3);
`endif
            sz = 1 + ((n == 0) ? 5 : n) * (2 * (h - l) + 2 * d);
            if (n == 0 || $urandom_range(0, 1) == 0)
                sa = $urandom_range(0, sz - 1);
            else
                sa = -1;
            run_case(l, h, n, d, sa);
            if (it % 5 == 0) begin
                l = $urandom_range(0, 255);
                err_case(l, $urandom_range(0, l));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
